// File: rtl/nn_pkg.sv
// Shared neural-datapath definitions: data width, sigmoid input range and
// the MAC neuron state encoding.
package nn_pkg;
    localparam int DATA_W  = 8;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } nn_state_t;
endpackage

// File: rtl/nn_shift_sat.sv
// Combinational scale-and-saturate: arithmetic right shift of a signed
// accumulator, clamped symmetrically to the sigmoid LUT input range.
module nn_shift_sat
    import nn_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] z
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN);

    // Symmetric clamp: -128 is never produced.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] t);
        if (t > MAX_V)
            return DATA_W'(SAT_MAX);
        else if (t < MIN_V)
            return DATA_W'(SAT_MIN);
        else
            return t[DATA_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        z       = sat(shifted);
    end

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron: bias plus N_INPUTS x*w products,
// scaled and saturated into the signed input range of the sigmoid stage.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] z,
    output logic                     busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    nn_state_t               state_q, state_d;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_scaled;
    logic signed [DATA_W-1:0] z_sat;
    logic                    hs_in;

    always_comb begin
        prod        = x * w;
        prod_ext    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        bias_scaled = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< SHIFT;
    end

    // Handshake flags depend on state only, so no in_valid -> in_ready path.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign hs_in     = in_valid && in_ready;

    nn_shift_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_shift_sat (
        .acc (acc),
        .z   (z_sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (hs_in && count == LAST) state_d = SCALE;
            SCALE:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc     <= '0;
            count   <= '0;
            z       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc   <= bias_scaled;
                        count <= '0;
                    end
                end
                ACCUM: begin
                    if (hs_in) begin
                        acc   <= acc + prod_ext;
                        count <= count + 1'b1;
                    end
                end
                SCALE:   z <= z_sat;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac (N_INPUTS=4, SHIFT=4) with hand-computed results.
module tb_neuron_mac;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic signed [7:0] bias = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] x = '0;
    logic signed [7:0] w = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] z;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_mac #(.N_INPUTS(4), .ACC_W(24), .SHIFT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // xs/ws packed as {p0,p1,p2,p3}; bp selects the gapped in_valid pattern.
    task automatic eval(input string nm, input logic signed [7:0] b,
                        input logic [31:0] xs, input logic [31:0] ws,
                        input bit bp, input int hold, input int exp_z);
        logic [6:0] pat;
        int k;
        pat = 7'b1011001;
        k = 0;
        start = 1'b1;
        bias  = b;
        cyc();
        start = 1'b0;
        bias  = '0;
        chk({nm, "_busy"}, busy, 1);
        if (bp) begin
            for (int i = 0; i < 7; i++) begin
                in_valid = pat[i];
                if (pat[i]) begin
                    x = xs[8*(3-k) +: 8];
                    w = ws[8*(3-k) +: 8];
                end else begin
                    x = 8'sd100;
                    w = 8'sd100;
                    start = 1'b1;
                    bias  = 8'sd50;
                end
                chk({nm, "_in_ready"}, in_ready, 1);
                cyc();
                if (pat[i]) k++;
                start = 1'b0;
                bias  = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                x = xs[8*(3-i) +: 8];
                w = ws[8*(3-i) +: 8];
                cyc();
            end
        end
        in_valid = 1'b0;
        x = '0;
        w = '0;
        chk({nm, "_scale_ov"}, out_valid, 0);
        chk({nm, "_scale_ir"}, in_ready, 0);
        cyc();
        chk({nm, "_lat_ov"}, out_valid, 1);
        for (int t = 0; t < 10 && !out_valid; t++) cyc();
        if (!out_valid) begin
            chk({nm, "_timeout"}, out_valid, 1);
            return;
        end
        chk({nm, "_z"}, z, exp_z);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start = 1'b1;
            bias  = 8'sd50;
            cyc();
            chk({nm, "_hold_ov"}, out_valid, 1);
            chk({nm, "_hold_z"}, z, exp_z);
            chk({nm, "_hold_ir"}, in_ready, 0);
        end
        start = 1'b0;
        bias  = '0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk({nm, "_done_ov"}, out_valid, 0);
        chk({nm, "_done_busy"}, busy, 0);
        chk({nm, "_idle_z"}, z, exp_z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_ir", in_ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_z", z, 0);
        rst = 1'b0;
        cyc();

        eval("basic", 8'sd0, {8'sd16, 8'sd16, 8'sd16, 8'sd16}, {8'sd1, 8'sd1, 8'sd1, 8'sd1}, 1'b0, 0, 4);
        eval("mixed", 8'sd3, {8'sd10, -8'sd10, 8'sd20, 8'sd0}, {8'sd8, 8'sd8, 8'sd8, 8'sd8}, 1'b0, 0, 13);
        eval("satp", 8'sd0, {4{8'sd127}}, {4{8'sd127}}, 1'b0, 0, 127);
        eval("satn", 8'sd0, {4{-8'sd128}}, {4{8'sd127}}, 1'b0, 0, -127);
        eval("floor", 8'sd0, {-8'sd1, 8'sd0, 8'sd0, 8'sd0}, {8'sd1, 8'sd1, 8'sd1, 8'sd1}, 1'b0, 0, -1);
        eval("bias1", 8'sd1, 32'd0, {8'sd1, 8'sd1, 8'sd1, 8'sd1}, 1'b0, 0, 1);
        eval("biasn", -8'sd1, 32'd0, 32'd0, 1'b0, 0, -1);
        eval("bp", 8'sd0, {8'sd16, 8'sd16, 8'sd16, 8'sd16}, {8'sd1, 8'sd1, 8'sd1, 8'sd1}, 1'b1, 5, 4);

        // Abort mid-ACCUM after two handshakes, with a nonzero z still held.
        eval("prez", 8'sd0, {4{8'sd127}}, {4{8'sd127}}, 1'b0, 0, 127);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x = 8'sd100;
            w = 8'sd100;
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ir", in_ready, 0);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_z", z, 0);
        cyc();
        cyc();
        chk("post_rst_ov", out_valid, 0);
        eval("fresh", 8'sd0, {8'sd16, 8'sd16, 8'sd16, 8'sd16}, {8'sd1, 8'sd1, 8'sd1, 8'sd1}, 1'b0, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
